// File: rtl/spi_slave_reg.sv
// SPI mode-0 slave exposing a four-entry 8-bit register file.
// Frame: {W,5'bx,addr[1:0]} then one data byte; reads return slv_reg[addr].
module spi_slave_reg #(
   parameter logic [7:0]  REG_INIT    = 8'h00,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sclk_i,
   input  logic       mosi_i,
   input  logic       cs_n_i,
   output logic       miso_o,
   output logic [7:0] slv_reg0_o,
   output logic [7:0] slv_reg1_o,
   output logic [7:0] slv_reg2_o,
   output logic [7:0] slv_reg3_o,
   output logic       wr_done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_prev_q;
   logic                   rise, fall;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] rx_q, rx_d;
   logic [7:0] rx_byte;
   logic [7:0] tx_q, tx_d;
   logic       w_q, w_d;
   logic [1:0] addr_q, addr_d;
   logic       first_q, first_d;
   logic       wr_q, wr_d;
   logic       armed_q, armed_d;
   logic [7:0] regs_q [4];
   logic [7:0] regs_d [4];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         vld_q       <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
         vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s    = cs_sync_q[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_prev_q;
   assign fall    = ~sclk_s & sclk_prev_q;
   assign rx_byte = {rx_q, mosi_s};

   // A frame may only start once cs_n has really been seen high after the
   // synchronizer has flushed, so a cs_n held low across reset is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      w_d     = w_q;
      addr_d  = addr_q;
      first_d = first_q;
      wr_d    = 1'b0;
      regs_d  = regs_q;
      armed_d = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
      unique case (state_q)
         IDLE: begin
            cnt_d   = '0;
            rx_d    = '0;
            tx_d    = '0;
            first_d = 1'b0;
            if (armed_q && !cs_s) state_d = CMD;
         end
         CMD: begin
            if (rise) begin
               rx_d  = rx_byte[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  w_d     = rx_q[6];
                  addr_d  = {rx_q[0], mosi_s};
                  first_d = 1'b1;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (rise) begin
               rx_d  = rx_byte[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = DONE;
                  if (w_q) begin
                     regs_d[addr_q] = rx_byte;
                     wr_d           = 1'b1;
                  end
               end
            end
            if (fall) begin
               first_d = 1'b0;
               tx_d    = first_q ? regs_q[addr_q] : {tx_q[6:0], 1'b0};
            end
         end
         DONE: begin
            state_d = DONE;
         end
      endcase
      if (cs_s && state_q != IDLE) begin
         state_d = IDLE;
         wr_d    = 1'b0;
         regs_d  = regs_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         w_q     <= 1'b0;
         addr_q  <= '0;
         first_q <= 1'b0;
         wr_q    <= 1'b0;
         armed_q <= 1'b0;
         for (int i = 0; i < 4; i++) regs_q[i] <= REG_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         w_q     <= w_d;
         addr_q  <= addr_d;
         first_q <= first_d;
         wr_q    <= wr_d;
         armed_q <= armed_d;
         regs_q  <= regs_d;
      end
   end

   assign miso_o     = tx_q[7] & ~cs_s & ((state_q == DATA) | (state_q == DONE));
   assign wr_done_o  = wr_q;
   assign slv_reg0_o = regs_q[0];
   assign slv_reg1_o = regs_q[1];
   assign slv_reg2_o = regs_q[2];
   assign slv_reg3_o = regs_q[3];

endmodule

// File: tb/tb_spi_slave_reg.sv
// Directed bench for spi_slave_reg: writes, reads, abort, extra edges, reset.
module tb_spi_slave_reg;

   localparam logic [7:0] INIT = 8'h3C;

   logic       clk = 1'b0;
   logic       rst_n, sclk, mosi, cs_n;
   logic       miso, wr_done;
   logic [7:0] r0, r1, r2, r3;

   int checks   = 0;
   int failures = 0;
   int wr_hi    = 0;
   int exp_wr   = 0;
   logic [31:0] snap = '0;
   logic [7:0]  rd, cm;

   spi_slave_reg #(.REG_INIT(INIT), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .mosi_i(mosi),
      .cs_n_i(cs_n), .miso_o(miso),
      .slv_reg0_o(r0), .slv_reg1_o(r1), .slv_reg2_o(r2), .slv_reg3_o(r3),
      .wr_done_o(wr_done)
   );

   always #5 clk = ~clk;

   // Count every clk cycle wr_done is high; snapshot the registers then.
   always @(negedge clk) begin
      if (wr_done === 1'b1) begin
         wr_hi = wr_hi + 1;
         snap  = {r3, r2, r1, r0};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] b0, input logic [7:0] b1,
                       input int nrise, input int extra, input bit raise_cs,
                       output logic [7:0] rdo, output logic [7:0] cmo);
      logic [15:0] f;
      f   = {b0, b1};
      rdo = '0;
      cmo = '0;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nrise + extra; i++) begin
         if (i < 16) mosi = f[15-i];
         else mosi = 1'b0;
         repeat (8) @(negedge clk);
         if (i < 8) cmo[7-i] = miso;
         else if (i < 16) rdo[15-i] = miso;
         sclk = 1'b1;
         repeat (8) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (8) @(negedge clk);
      if (raise_cs) begin
         cs_n = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_r0", r0, INIT);
      chk("rst_r1", r1, INIT);
      chk("rst_r2", r2, INIT);
      chk("rst_r3", r3, INIT);
      chk("rst_miso", miso, 0);
      chk("rst_wr", wr_done, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      xfer(8'h82, 8'h5A, 16, 0, 1, rd, cm);
      exp_wr = exp_wr + 1;
      chk("w2_r2", r2, 8'h5A);
      chk("w2_r0", r0, INIT);
      chk("w2_r1", r1, INIT);
      chk("w2_r3", r3, INIT);
      chk("w2_wr", wr_hi, exp_wr);
      chk("w2_snap", snap[23:16], 8'h5A);

      xfer(8'h83, 8'hC3, 16, 0, 1, rd, cm);
      exp_wr = exp_wr + 1;
      chk("w3_r3", r3, 8'hC3);
      xfer(8'h03, 8'h00, 16, 0, 1, rd, cm);
      chk("rd3_data", rd, 8'hC3);
      chk("rd3_cmd_miso", cm, 8'h00);
      chk("rd3_r3", r3, 8'hC3);
      chk("rd3_r2", r2, 8'h5A);
      chk("rd3_wr", wr_hi, exp_wr);
      chk("rd3_idle_miso", miso, 0);

      xfer(8'h81, 8'hFF, 12, 0, 1, rd, cm);
      chk("abort_r1", r1, INIT);
      chk("abort_wr", wr_hi, exp_wr);
      xfer(8'h81, 8'h11, 16, 0, 1, rd, cm);
      exp_wr = exp_wr + 1;
      chk("w1_r1", r1, 8'h11);
      chk("w1_wr", wr_hi, exp_wr);

      xfer(8'h80, 8'hA5, 16, 8, 1, rd, cm);
      exp_wr = exp_wr + 1;
      chk("extra_r0", r0, 8'hA5);
      chk("extra_wr", wr_hi, exp_wr);

      xfer(8'h80, 8'h77, 10, 0, 0, rd, cm);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mrst_r0", r0, INIT);
      chk("mrst_r1", r1, INIT);
      chk("mrst_r2", r2, INIT);
      chk("mrst_r3", r3, INIT);
      chk("mrst_miso", miso, 0);
      chk("mrst_wr", wr_done, 0);
      rst_n = 1'b1;
      xfer(8'h77, 8'h00, 6, 0, 1, rd, cm);
      chk("post_rst_r0", r0, INIT);
      chk("post_rst_wr", wr_hi, exp_wr);

      xfer(8'h80, 8'h01, 16, 0, 1, rd, cm);
      xfer(8'h81, 8'h02, 16, 0, 1, rd, cm);
      xfer(8'h82, 8'h04, 16, 0, 1, rd, cm);
      xfer(8'h83, 8'h08, 16, 0, 1, rd, cm);
      exp_wr = exp_wr + 4;
      chk("b2b_r0", r0, 8'h01);
      chk("b2b_r1", r1, 8'h02);
      chk("b2b_r2", r2, 8'h04);
      chk("b2b_r3", r3, 8'h08);
      chk("b2b_wr", wr_hi, exp_wr);

      xfer(8'h02, 8'hFF, 16, 0, 1, rd, cm);
      chk("rd2_data", rd, 8'h04);
      chk("rd2_r2", r2, 8'h04);
      chk("rd2_wr", wr_hi, exp_wr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_reg.md
SPI_SLAVE_REG -- requirements
Module: spi_slave_reg

Interface
REQ-001 Parameter REG_INIT, default 8'h00: value loaded into all four registers on reset.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, mosi and cs_n; legal range 2..3.
REQ-003 clk  input  1  system clock; the single clock domain of the block.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 sclk  input  1  SPI serial clock from the master; asynchronous to clk.
REQ-006 mosi  input  1  SPI data from the master, MSB first.
REQ-007 cs_n  input  1  SPI chip select, active-low.
REQ-008 miso  output  1  SPI data to the master, MSB first.
REQ-009 slv_reg0..slv_reg3  output  8 each  register file contents feeding the FND display mux.
REQ-010 wr_done  output  1  one-clk pulse on each committed write.

Function
REQ-011 The block shall pass sclk, mosi and cs_n through SYNC_STAGES flops, then detect sclk rising and falling edges in the clk domain.
REQ-012 Supported SPI mode: mode 0 only (CPOL=0, CPHA=0); mosi sampled on sclk rising edges; miso changed on sclk falling edges.
REQ-013 The clock ratio shall satisfy f_sclk <= f_clk/8; behaviour above that ratio is undefined.
REQ-014 Frame format: 16 bits.
  - Byte0: bit7 = W (1 write, 0 read), bits6:2 ignored, bits1:0 = addr.
  - Byte1: write data (write frame) or don't-care (read frame).
REQ-015 FSM states:
  - IDLE -> CMD on synchronized cs_n falling.
  - CMD -> DATA after 8th rising edge.
  - DATA -> DONE after 16th rising edge.
  - DONE -> IDLE on cs_n high.
  - Any state -> IDLE on cs_n high.
REQ-016 A 4-bit bit counter shall clear in IDLE and increment on every detected rising edge in CMD and DATA.
REQ-017 After the 8th rising edge, the block shall latch W and addr from the command shift register.
REQ-018 Write commit: on the clk cycle after the 16th rising edge is detected with W=1:
  - slv_reg[addr] <= byte1;
  - wr_done = 1 for exactly that cycle.
  - The other three registers shall be unchanged.
REQ-019 Read frames shall never modify any register and shall never pulse wr_done.
REQ-020 Read data: on the falling edge following the 8th rising edge, the miso shift register shall load slv_reg[addr] and miso shall equal bit7; each subsequent falling edge shifts left one bit.
REQ-021 miso shall be 0 in IDLE, in CMD, and whenever cs_n is high.
REQ-022 In DONE, extra sclk edges beyond 16 shall be ignored: no shift, no second commit.
REQ-023 Abort: cs_n deasserted before the 16th rising edge shall discard the frame with no register change and no wr_done.
REQ-024 Back-to-back frames (cs_n high for at least 2 synchronized clk cycles between frames) shall each be decoded independently.
REQ-025 Each slv_regN output shall be driven directly from a flop (no combinational path from SPI inputs).

Reset
REQ-026 While reset is low, the block shall hold:
  - slv_reg0..3 = REG_INIT;
  - miso = 0;
  - wr_done = 0;
  - FSM = IDLE;
  - bit counter = 0;
  - shift registers = 0;
  - synchronizer flops = idle values (sclk=0, cs_n=1).
REQ-027 Reset asserted mid-frame shall abort the frame immediately.
REQ-028 After reset release, the block shall require a fresh cs_n falling edge before accepting bits.

Verification
REQ-029 Write frame 8'h82, 8'h5A -> slv_reg2 = 8'h5A one clk after 16th edge; wr_done high 1 cycle; slv_reg0/1/3 unchanged.
REQ-030 Write 8'h83, 8'hC3, then read frame 8'h03, 8'h00 -> miso bits sampled on rising edges 9..16 = 1100_0011; no register change; no wr_done.
REQ-031 Write 8'h81, 8'hFF with cs_n raised after 12 rising edges -> slv_reg1 stays at REG_INIT; wr_done never pulses; next full frame 8'h81, 8'h11 -> slv_reg1 = 8'h11.
REQ-032 Write 8'h80, 8'hA5 followed by 8 extra sclk cycles before cs_n high -> slv_reg0 = 8'hA5; exactly one wr_done pulse.
REQ-033 Assert reset low after 10 rising edges of write 8'h80, 8'h77 -> all registers = REG_INIT, miso = 0; frame discarded after release.
REQ-034 Four back-to-back writes to addr 0..3 with data 8'h01, 8'h02, 8'h04, 8'h08 -> slv_reg0..3 = 01/02/04/08; four wr_done pulses.
